hyperbus_dev_responder: RTL and testbench

Device-side (memory-end) HyperBus responder, the counterpart of the host's RWDS sampler.
- Deserialises the 48-bit command-address (CA).
- Drives RWDS during CA to signal single or double initial latency, and counts that latency.
- On reads: sources data with a toggling RWDS strobe, and stalls by holding RWDS. On writes: captures data and uses host RWDS as the byte mask.
- Used in the testbench and FPGA device emulation. Bus-side signals arrive pre-synchronised at edge rate.

---
 rtl/hyperbus_pkg.sv | 31 +++
 rtl/hyperbus_ca_deser.sv | 43 ++++
 rtl/hyperbus_dev_responder.sv | 215 +++++++++++++++++++++
 tb/tb_hyperbus_dev_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// Shared types for the device-side HyperBus responder: CA layout, FSM states
// and the initial-latency edge count.
package hyperbus_pkg;

    localparam int CaEdges = 6;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        READ,
        WRITE
    } dev_state_e;

    typedef struct packed {
        logic        rw;
        logic        as;
        logic        burst;
        logic [28:0] addr_hi;
        logic [12:0] rsvd;
        logic [2:0]  addr_lo;
    } hyper_ca_t;

    // Edges spent in LAT after CA: 2*latency CK edges, doubled when dbl, minus the CA overlap.
    function automatic logic [7:0] latency_edges(input logic [3:0] lat, input logic dbl);
        logic [7:0] edges;
        edges = {3'b000, lat, 1'b0} << dbl;
        return edges - 8'd4;
    endfunction

endpackage

// File: rtl/hyperbus_ca_deser.sv
// Six-edge command-address deserialiser; done_o flags the edge carrying the last CA byte,
// with ca_o presenting the complete CA on that same edge.
module hyperbus_ca_deser
    import hyperbus_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output hyper_ca_t  ca_o
);

    logic [8*(CaEdges-1)-1:0] shreg_q, shreg_d;
    logic [2:0]               cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            shreg_d = {{(8*(CaEdges-2)){1'b0}}, data_i};
            cnt_d   = 3'd1;
        end else if (shift_i) begin
            shreg_d = {shreg_q[8*(CaEdges-2)-1:0], data_i};
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done_o = shift_i && (cnt_q == 3'(CaEdges - 1));
    assign ca_o   = {shreg_q, data_i};

endmodule

// File: rtl/hyperbus_dev_responder.sv
// Device-end HyperBus responder: decodes CA, signals and counts initial latency,
// sources read data with an RWDS strobe and captures masked write data.
module hyperbus_dev_responder
    import hyperbus_pkg::*;
#(
    parameter int AddrWidth   = 32,
    parameter int LatCntWidth = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [3:0]           cfg_latency_i,
    input  logic                 cfg_fixed_lat_i,
    input  logic                 refresh_busy_i,
    input  logic                 hyper_cs_ni,
    input  logic [7:0]           hyper_dq_i,
    output logic [7:0]           hyper_dq_o,
    output logic                 hyper_dq_oe_o,
    input  logic                 hyper_rwds_i,
    output logic                 hyper_rwds_o,
    output logic                 hyper_rwds_oe_o,
    output logic                 req_valid_o,
    output logic                 req_write_o,
    output logic                 req_regspace_o,
    output logic                 req_wrap_o,
    output logic [AddrWidth-1:0] req_addr_o,
    input  logic                 rdata_valid_i,
    input  logic [15:0]          rdata_i,
    output logic                 rdata_ready_o,
    output logic                 wdata_valid_o,
    output logic [15:0]          wdata_o,
    output logic [1:0]           wstrb_o
);

    dev_state_e             state_q, state_d;
    logic                   dbl_q, dbl_d;
    logic [3:0]             lat_q, lat_d;
    logic [LatCntWidth-1:0] latCnt_q, latCnt_d;
    logic                   toWrite_q, toWrite_d;
    logic                   phase_q, phase_d;
    logic [7:0]             dqOut_q, dqOut_d;
    logic [7:0]             byteHi_q, byteHi_d;
    logic                   rwdsHi_q, rwdsHi_d;
    logic                   reqValid_q, reqValid_d;
    logic                   reqWrite_q, reqWrite_d;
    logic                   reqRegspace_q, reqRegspace_d;
    logic                   reqWrap_q, reqWrap_d;
    logic [AddrWidth-1:0]   reqAddr_q, reqAddr_d;
    logic                   wdValid_q, wdValid_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [1:0]             wstrb_q, wstrb_d;

    logic      csActive;
    logic      caDone;
    hyper_ca_t caWord;
    logic [7:0] latEdges;
    logic      latDone;
    logic      unusedCaBits;

    assign csActive     = ~hyper_cs_ni;
    assign latEdges     = latency_edges(lat_q, dbl_q);
    assign latDone      = (32'(latCnt_q) + 32'd1) >= 32'(latEdges);
    assign unusedCaBits = ^caWord.rsvd;

    hyperbus_ca_deser u_ca_deser (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i ((state_q == IDLE) && csActive),
        .shift_i ((state_q == CA) && csActive),
        .data_i  (hyper_dq_i),
        .done_o  (caDone),
        .ca_o    (caWord)
    );

    always_comb begin
        state_d         = state_q;
        dbl_d           = dbl_q;
        lat_d           = lat_q;
        latCnt_d        = latCnt_q;
        toWrite_d       = toWrite_q;
        phase_d         = phase_q;
        dqOut_d         = dqOut_q;
        byteHi_d        = byteHi_q;
        rwdsHi_d        = rwdsHi_q;
        reqValid_d      = 1'b0;
        reqWrite_d      = reqWrite_q;
        reqRegspace_d   = reqRegspace_q;
        reqWrap_d       = reqWrap_q;
        reqAddr_d       = reqAddr_q;
        wdValid_d       = 1'b0;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        hyper_dq_o      = dqOut_q;
        hyper_dq_oe_o   = 1'b0;
        hyper_rwds_o    = 1'b0;
        hyper_rwds_oe_o = 1'b0;
        rdata_ready_o   = 1'b0;

        // Deselect aborts whatever is in flight; every bus-facing strobe stays gated by CS.
        if (!csActive) begin
            state_d = IDLE;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    dbl_d           = cfg_fixed_lat_i | refresh_busy_i;
                    lat_d           = cfg_latency_i;
                    hyper_rwds_oe_o = 1'b1;
                    hyper_rwds_o    = dbl_d;
                    state_d         = CA;
                end
                CA: begin
                    hyper_rwds_oe_o = 1'b1;
                    hyper_rwds_o    = dbl_q;
                    if (caDone) begin
                        reqValid_d    = 1'b1;
                        reqWrite_d    = ~caWord.rw;
                        reqRegspace_d = caWord.as;
                        reqWrap_d     = ~caWord.burst;
                        reqAddr_d     = AddrWidth'({caWord.addr_hi, caWord.addr_lo});
                        latCnt_d      = '0;
                        phase_d       = 1'b0;
                        toWrite_d     = ~caWord.rw;
                        state_d       = (!caWord.rw && caWord.as) ? WRITE : LAT;
                    end
                end
                LAT: begin
                    latCnt_d = (&latCnt_q) ? latCnt_q : latCnt_q + LatCntWidth'(1);
                    if (latDone) begin
                        state_d = toWrite_q ? WRITE : READ;
                    end
                end
                READ: begin
                    hyper_dq_oe_o   = 1'b1;
                    hyper_rwds_oe_o = 1'b1;
                    if (!phase_q) begin
                        if (rdata_valid_i) begin
                            hyper_rwds_o = 1'b1;
                            hyper_dq_o   = rdata_i[15:8];
                            dqOut_d      = rdata_i[15:8];
                            phase_d      = 1'b1;
                        end
                    end else begin
                        hyper_dq_o    = rdata_i[7:0];
                        dqOut_d       = rdata_i[7:0];
                        rdata_ready_o = 1'b1;
                        phase_d       = 1'b0;
                    end
                end
                WRITE: begin
                    if (!phase_q) begin
                        byteHi_d = hyper_dq_i;
                        rwdsHi_d = hyper_rwds_i;
                        phase_d  = 1'b1;
                    end else begin
                        wdata_d   = {byteHi_q, hyper_dq_i};
                        wstrb_d   = ~{rwdsHi_q, hyper_rwds_i};
                        wdValid_d = 1'b1;
                        phase_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            dbl_q         <= 1'b0;
            lat_q         <= '0;
            latCnt_q      <= '0;
            toWrite_q     <= 1'b0;
            phase_q       <= 1'b0;
            dqOut_q       <= '0;
            byteHi_q      <= '0;
            rwdsHi_q      <= 1'b0;
            reqValid_q    <= 1'b0;
            reqWrite_q    <= 1'b0;
            reqRegspace_q <= 1'b0;
            reqWrap_q     <= 1'b0;
            reqAddr_q     <= '0;
            wdValid_q     <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            dbl_q         <= dbl_d;
            lat_q         <= lat_d;
            latCnt_q      <= latCnt_d;
            toWrite_q     <= toWrite_d;
            phase_q       <= phase_d;
            dqOut_q       <= dqOut_d;
            byteHi_q      <= byteHi_d;
            rwdsHi_q      <= rwdsHi_d;
            reqValid_q    <= reqValid_d;
            reqWrite_q    <= reqWrite_d;
            reqRegspace_q <= reqRegspace_d;
            reqWrap_q     <= reqWrap_d;
            reqAddr_q     <= reqAddr_d;
            wdValid_q     <= wdValid_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
        end
    end

    assign req_valid_o    = reqValid_q;
    assign req_write_o    = reqWrite_q;
    assign req_regspace_o = reqRegspace_q;
    assign req_wrap_o     = reqWrap_q;
    assign req_addr_o     = reqAddr_q;
    assign wdata_valid_o  = wdValid_q;
    assign wdata_o        = wdata_q;
    assign wstrb_o        = wstrb_q;

endmodule

// File: tb/tb_hyperbus_dev_responder.sv
// Scoreboard bench for hyperbus_dev_responder: a host-side driver pushes expected
// requests, read bytes and write words; an independent monitor pops and compares.
module tb_hyperbus_dev_responder;
    import hyperbus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cfgLatency;
    logic        cfgFixedLat;
    logic        refreshBusy;
    logic        csN;
    logic [7:0]  dqIn;
    logic [7:0]  dqOut;
    logic        dqOe;
    logic        rwdsIn;
    logic        rwdsOut;
    logic        rwdsOe;
    logic        reqValid;
    logic        reqWrite;
    logic        reqRegspace;
    logic        reqWrap;
    logic [31:0] reqAddr;
    logic        rdataValid;
    logic [15:0] rdata;
    logic        rdataReady;
    logic        wdataValid;
    logic [15:0] wdata;
    logic [1:0]  wstrb;

    typedef struct {
        bit          write;
        bit          regspace;
        bit          wrap;
        logic [31:0] addr;
    } reqExp_t;

    reqExp_t     expReq[$];
    int          expLat[$];
    logic [8:0]  expRd[$];
    logic [17:0] expWr[$];

    int vectors = 0;
    int miscompares = 0;

    hyperbus_dev_responder #(.AddrWidth(32), .LatCntWidth(6)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_latency_i   (cfgLatency),
        .cfg_fixed_lat_i (cfgFixedLat),
        .refresh_busy_i  (refreshBusy),
        .hyper_cs_ni     (csN),
        .hyper_dq_i      (dqIn),
        .hyper_dq_o      (dqOut),
        .hyper_dq_oe_o   (dqOe),
        .hyper_rwds_i    (rwdsIn),
        .hyper_rwds_o    (rwdsOut),
        .hyper_rwds_oe_o (rwdsOe),
        .req_valid_o     (reqValid),
        .req_write_o     (reqWrite),
        .req_regspace_o  (reqRegspace),
        .req_wrap_o      (reqWrap),
        .req_addr_o      (reqAddr),
        .rdata_valid_i   (rdataValid),
        .rdata_i         (rdata),
        .rdata_ready_o   (rdataReady),
        .wdata_valid_o   (wdataValid),
        .wdata_o         (wdata),
        .wstrb_o         (wstrb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: event seen with nothing expected", name);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Deselect for one edge; output enables must already be low in that cycle
    task automatic endTransfer(input string name);
        csN = 1'b1;
        rdataValid = 1'b0;
        @(negedge clk);
        checkOutput({name, "_dq_oe"}, dqOe, 0);
        checkOutput({name, "_rwds_oe"}, rwdsOe, 0);
        nextCycle();
    endtask

    // One host transfer; expectations come from the HyperBus rules, not from DUT state
    task automatic applyStimulus(input logic [47:0] ca, input int lat, input bit fixed, input bit refr,
                                 input int nWords, input logic [15:0] firstWord, input logic [1:0] firstMask,
                                 input int stall, input int abortCa, input bit abortMid, input int rstAt);
        bit          isRead;
        bit          isReg;
        bit          dbl;
        int          w;
        int          lead;
        logic [15:0] words[$];
        logic [1:0]  masks[$];
        reqExp_t     r;
        isRead = ca[47];
        isReg  = ca[46];
        dbl    = fixed | refr;
        w      = 2 * lat * (dbl ? 2 : 1) - 4;
        for (int k = 0; k < nWords; k++) begin
            words.push_back(k == 0 ? firstWord : 16'($urandom));
            masks.push_back(k == 0 ? firstMask : 2'($urandom));
        end
        if (abortCa < 0) begin
            r.write    = ~ca[47];
            r.regspace = ca[46];
            r.wrap     = ~ca[45];
            r.addr     = {ca[44:16], ca[2:0]};
            expReq.push_back(r);
            if (isRead) expLat.push_back(w);
        end

        cfgLatency  = 4'(lat);
        cfgFixedLat = fixed;
        refreshBusy = refr;
        for (int e = 0; e < CaEdges; e++) begin
            if (e == abortCa) begin
                endTransfer("ca_abort");
                return;
            end
            csN  = 1'b0;
            dqIn = ca[47-8*e -: 8];
            @(negedge clk);
            checkOutput("ca_rwds_oe", rwdsOe, 1);
            checkOutput("ca_rwds", rwdsOut, dbl);
            nextCycle();
            cfgLatency  = 4'($urandom_range(3, 7));
            cfgFixedLat = 1'($urandom);
            refreshBusy = 1'($urandom);
        end

        if (isRead) begin
            for (int k = 0; k < nWords; k++) begin
                if (rstAt < 0 || k < rstAt) begin
                    expRd.push_back({words[k][15:8], 1'b1});
                    expRd.push_back({words[k][7:0], 1'b0});
                end
            end
            rdataValid = 1'b0;
            rdata = words[0];
            for (int c = 0; c < w + stall; c++) begin
                @(negedge clk);
                if (c >= w) begin
                    checkOutput("stall_rwds", rwdsOut, 0);
                    checkOutput("stall_ready", rdataReady, 0);
                end
                nextCycle();
            end
            for (int k = 0; k < nWords; k++) begin
                if (k == rstAt) begin
                    rst = 1'b1;
                    rdataValid = 1'b0;
                    nextCycle();
                    rst = 1'b0;
                    csN = 1'b1;
                    @(negedge clk);
                    checkOutput("rst_outputs",
                                {dqOut, dqOe, rwdsOut, rwdsOe, reqValid, reqWrite, reqRegspace, reqWrap,
                                 rdataReady, wdataValid, wstrb}, 0);
                    checkOutput("rst_data", {reqAddr, wdata}, 0);
                    nextCycle();
                    return;
                end
                rdata = words[k];
                rdataValid = 1'b1;
                @(negedge clk);
                nextCycle();
                @(negedge clk);
                nextCycle();
            end
            endTransfer("rd_end");
        end else begin
            lead = isReg ? 0 : w;
            for (int c = 0; c < lead; c++) begin
                dqIn = 8'($urandom);
                rwdsIn = 1'($urandom);
                @(negedge clk);
                nextCycle();
            end
            for (int k = 0; k < nWords; k++) begin
                expWr.push_back({words[k], ~masks[k]});
                dqIn = words[k][15:8];
                rwdsIn = masks[k][1];
                @(negedge clk);
                nextCycle();
                dqIn = words[k][7:0];
                rwdsIn = masks[k][0];
                @(negedge clk);
                nextCycle();
            end
            if (abortMid) begin
                dqIn = 8'($urandom);
                rwdsIn = 1'b0;
                @(negedge clk);
                nextCycle();
            end
            endTransfer(abortMid ? "wr_abort" : "wr_end");
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a request, data edge or write word
    initial begin : monitor
        reqExp_t r;
        bit      latArmed;
        int      latCount;
        int      latWant;
        latArmed = 1'b0;
        latCount = 0;
        latWant  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (reqValid) begin
                    if (expReq.size() == 0) begin
                        reportUnexpected("req_valid");
                    end else begin
                        r = expReq.pop_front();
                        checkOutput("req_write", reqWrite, r.write);
                        checkOutput("req_regspace", reqRegspace, r.regspace);
                        checkOutput("req_wrap", reqWrap, r.wrap);
                        checkOutput("req_addr", reqAddr, r.addr);
                        if (!r.write) begin
                            latArmed = 1'b1;
                            latCount = 0;
                            latWant  = (expLat.size() != 0) ? expLat.pop_front() : -1;
                        end
                    end
                end else if (latArmed) begin
                    latCount++;
                    if (dqOe) begin
                        checkOutput("latency", latCount, latWant);
                        latArmed = 1'b0;
                    end else if (csN || latCount > 64) begin
                        reportUnexpected("latency_timeout");
                        latArmed = 1'b0;
                    end
                end
                if (dqOe && (rwdsOut || rdataReady)) begin
                    if (expRd.size() == 0) reportUnexpected("read_edge");
                    else checkOutput("read_edge", {dqOut, rwdsOut}, expRd.pop_front());
                end
                if (wdataValid) begin
                    if (expWr.size() == 0) reportUnexpected("wdata_valid");
                    else checkOutput("wdata", {wdata, wstrb}, expWr.pop_front());
                end
            end
        end
    end

    initial begin : driver
        logic [47:0] ca;
        int          kind;
        rst = 1'b1;
        csN = 1'b1;
        cfgLatency = 4'd6;
        cfgFixedLat = 1'b0;
        refreshBusy = 1'b0;
        dqIn = '0;
        rwdsIn = 1'b0;
        rdataValid = 1'b0;
        rdata = '0;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("reset_state",
                    {dqOut, dqOe, rwdsOut, rwdsOe, reqValid, rdataReady, wdataValid, wstrb}, 0);
        checkOutput("reset_data", {reqAddr, wdata}, 0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("[TB] directed transfers");
        applyStimulus(48'hA0_0000_0001, 6, 0, 0, 2, 16'hBEEF, 2'b00, 0, -1, 0, -1);
        applyStimulus(48'hA0_1234_5006, 6, 0, 1, 1, 16'h5A3C, 2'b00, 0, -1, 0, -1);
        applyStimulus(48'h20_0000_0002, 3, 0, 0, 1, 16'h1234, 2'b01, 0, -1, 0, -1);
        applyStimulus(48'h40_0000_0001, 6, 0, 0, 1, 16'h8F1F, 2'b00, 0, -1, 0, -1);
        applyStimulus(48'hE0_0003_0105, 4, 1, 0, 3, 16'hC0DE, 2'b00, 5, -1, 0, -1);
        applyStimulus(48'hA0_0000_0007, 5, 0, 0, 1, 16'h1111, 2'b00, 0, 3, 0, -1);
        applyStimulus(48'hA0_0007_0003, 5, 0, 0, 1, 16'h7E81, 2'b00, 0, -1, 0, -1);
        applyStimulus(48'h00_0100_0004, 3, 0, 0, 1, 16'hA55A, 2'b10, 0, -1, 1, -1);
        applyStimulus(48'h20_0000_0006, 7, 0, 0, 2, 16'h0FF0, 2'b00, 0, -1, 0, -1);
        applyStimulus(48'hA0_0000_0000, 3, 0, 0, 3, 16'h2468, 2'b00, 0, -1, 0, 1);
        applyStimulus(48'hA0_0002_0002, 3, 0, 0, 1, 16'h1357, 2'b00, 0, -1, 0, -1);

        $display("[TB] random transfers");
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            ca = {kind[1] ? 1'b0 : 1'b1, kind[0], 1'($urandom), 29'($urandom), 13'b0, 3'($urandom)};
            applyStimulus(ca, int'($urandom_range(3, 7)), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0), int'($urandom_range(1, 4)), 16'($urandom),
                          2'($urandom), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : -1,
                          ($urandom_range(0, 5) == 0), -1);
        end

        repeat (4) nextCycle();
        checkOutput("req_queue_empty", expReq.size(), 0);
        checkOutput("rd_queue_empty", expRd.size(), 0);
        checkOutput("wr_queue_empty", expWr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
